// File: rtl/tc_pkg.sv
// tc_pkg: definitions shared by the texture-cache MRA arbiter slice.
//   - requester index constants (tc_fsm, pf_core, simd_core)
//   - arbiter FSM state type
//   - default MRA tag width
//   - helper for index widths of small requester counts
package tc_pkg;

  localparam int REQ_TC   = 0;
  localparam int REQ_PF   = 1;
  localparam int REQ_SIMD = 2;

  localparam int DEF_TAG_WIDTH = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,  // no request presented to the MRA
    ARB_HOLD = 1'b1   // request presented, waiting for mra_req_ready
  } arb_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_rr_arb.sv
// tc_rr_arb: combinational round-robin picker.
//   req     - request vector
//   ptr     - index of the last granted requester; search starts at ptr+1
//   gnt     - one-hot grant
//   gnt_idx - binary index of the granted requester
//   gnt_any - some requester was granted
module tc_rr_arb
  import tc_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int unsigned p;

  // Two passes: indices above the pointer first, then wrap to the bottom.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    p       = 32'(ptr);
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req[i] && (i > p)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        gnt_any = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req[i] && (i <= p)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc_mra_arb.sv
// tc_mra_arb: arbitrates NUM_REQ requesters onto a single tagged MRA port.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/ready/addr/we/wdata
//                              - per-requester request channel (flat vectors)
//   mra_req_*                  - registered request to the MRA with tag
//   mra_rsp_valid/tag/data     - MRA response (no backpressure)
//   rsp_valid, rsp_data        - one-hot response strobe to the tag owner,
//                                shared response data
//   busy                       - any tag outstanding
module tc_mra_arb
  import tc_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int NUM_REQ    = 3,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic                            mra_req_valid,
  input  logic                            mra_req_ready,
  output logic [ADDR_WIDTH-1:0]           mra_req_addr,
  output logic                            mra_req_we,
  output logic [DATA_WIDTH-1:0]           mra_req_data,
  output logic [TAG_WIDTH-1:0]            mra_req_tag,
  input  logic                            mra_rsp_valid,
  input  logic [TAG_WIDTH-1:0]            mra_rsp_tag,
  input  logic [DATA_WIDTH-1:0]           mra_rsp_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            busy
);

  localparam int NUM_TAGS = 1 << TAG_WIDTH;
  localparam int IDX_W    = idx_width(NUM_REQ);

  arb_state_t state_q, state_d;

  logic [NUM_TAGS-1:0]   busy_q;
  logic [NUM_TAGS-1:0]   tag_set;
  logic [NUM_TAGS-1:0]   tag_clr;
  logic [IDX_W-1:0]      owner_q [NUM_TAGS];
  logic [IDX_W-1:0]      last_q;
  logic [IDX_W-1:0]      win_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;

  logic                  tag_avail;
  logic [TAG_WIDTH-1:0]  free_tag;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  grant_now;
  logic                  hs;
  logic                  rsp_hit;

  tc_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Lowest-numbered free tag, from the registered map only: a tag returned
  // this cycle is still marked busy here.
  always_comb begin
    tag_avail = 1'b0;
    free_tag  = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!tag_avail && !busy_q[i]) begin
        tag_avail = 1'b1;
        free_tag  = TAG_WIDTH'(i);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_we   = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we   = req_we[i];
        sel_data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_now = (state_q == ARB_IDLE) && gnt_any && tag_avail;
  assign hs        = (state_q == ARB_HOLD) && mra_req_ready;
  assign rsp_hit   = mra_rsp_valid && busy_q[mra_rsp_tag];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant_now) state_d = ARB_HOLD;
      ARB_HOLD: if (mra_req_ready) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    tag_set   = '0;
    tag_clr   = '0;
    rsp_valid = '0;
    if (hs) begin
      req_ready[win_q]   = 1'b1;
      tag_set[mra_req_tag] = 1'b1;
    end
    // Responses on tags that are not outstanding are dropped silently.
    if (rsp_hit) begin
      rsp_valid[owner_q[mra_rsp_tag]] = 1'b1;
      tag_clr[mra_rsp_tag]            = 1'b1;
    end
  end

  assign mra_req_valid = (state_q == ARB_HOLD);
  assign rsp_data      = mra_rsp_data;
  assign busy          = |busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      busy_q       <= '0;
      last_q       <= IDX_W'(NUM_REQ - 1);
      win_q        <= '0;
      mra_req_addr <= '0;
      mra_req_we   <= 1'b0;
      mra_req_data <= '0;
      mra_req_tag  <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) owner_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // Set and clear never target the same tag (set uses a free one).
      busy_q  <= (busy_q & ~tag_clr) | tag_set;
      if (grant_now) begin
        win_q        <= gnt_idx;
        mra_req_addr <= sel_addr;
        mra_req_we   <= sel_we;
        mra_req_data <= sel_data;
        mra_req_tag  <= free_tag;
      end
      if (hs) begin
        owner_q[mra_req_tag] <= win_q;
        last_q               <= win_q;
      end
    end
  end

endmodule
